// File: rtl/field_edit_ctrl.sv
// Edit-state field sequencer: increment (and, with DEC_BTN_EN, decrement) with auto-repeat,
// wrapped write-back and a follow-up day clamp after month/year edits.
module field_edit_ctrl #(
    parameter int unsigned REPEAT_DELAY  = 10_000_000,
    parameter int unsigned REPEAT_PERIOD = 2_000_000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic       inc_btn,
`ifdef DEC_BTN_EN
    input  logic       dec_btn,
`endif
    input  logic [6:0] rd_data,
    input  logic [4:0] date_day,
    input  logic [3:0] date_month,
    input  logic [6:0] date_year,
    output logic [1:0] rd_target,
    output logic [2:0] rd_field,
    output logic       wr_en,
    output logic [1:0] wr_target,
    output logic [2:0] wr_field,
    output logic [6:0] wr_data,
    output logic       busy,
    output logic       edit_active
);

    typedef enum logic [1:0] {IDLE, WRITE, SETTLE, CLAMP} fsm_t;

    localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    function automatic logic [6:0] dim(input logic [3:0] m, input logic [6:0] y);
        case (m)
            4'd2:                    dim = ((y & 7'd3) == 7'd0) ? 7'd29 : 7'd28;
            4'd4, 4'd6, 4'd9, 4'd11: dim = 7'd30;
            default:                 dim = 7'd31;
        endcase
    endfunction

    fsm_t             fsm;
    logic [3:0]       state_prev;
    logic             state_chg;
    logic             both_low;
    logic             inc_prev;
    logic [CNT_W-1:0] inc_cnt;
    logic             inc_ev_raw;
    logic             inc_ev;
    logic             dec_ev;
    logic [6:0]       fmin;
    logic [6:0]       fmax;
    logic [6:0]       inc_val;
    logic [6:0]       dec_val;
    logic [6:0]       next_val;
    logic [6:0]       settle_dim;
    logic             accept;

    always_comb begin
        rd_target   = 2'd0;
        rd_field    = 3'd0;
        edit_active = 1'b0;
        case (state)
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
                edit_active = 1'b1;
                rd_field    = 3'(state - 4'd2);
            end
            4'd9, 4'd10, 4'd11: begin
                edit_active = 1'b1;
                rd_target   = 2'd1;
                rd_field    = 3'(state - 4'd9);
            end
            4'd13, 4'd14, 4'd15: begin
                edit_active = 1'b1;
                rd_target   = 2'd2;
                rd_field    = 3'(state - 4'd13);
            end
            default: ;
        endcase
    end

    always_comb begin
        fmin = 7'd0;
        fmax = 7'd59;
        case (rd_field)
            3'd2: fmax = 7'd23;
            3'd3: begin
                fmin = 7'd1;
                fmax = dim(date_month, date_year);
            end
            3'd4: begin
                fmin = 7'd1;
                fmax = 7'd12;
            end
            3'd5: fmax = 7'd99;
            default: ;
        endcase
    end

    // Out-of-range reads (above max, or zero day/month) snap to the field minimum.
    assign inc_val  = (rd_data >= fmax || rd_data < fmin) ? fmin : rd_data + 7'd1;
    assign dec_val  = (rd_data > fmax || rd_data < fmin) ? fmin :
                      (rd_data == fmin) ? fmax : rd_data - 7'd1;
    assign state_chg = (state != state_prev);

    assign inc_ev_raw = (!inc_btn && inc_prev) ||
                        (!inc_btn && !state_chg && !both_low && inc_cnt == DELAY_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_prev   <= 1'b1;
            inc_cnt    <= '0;
            state_prev <= '0;
        end else begin
            inc_prev   <= inc_btn;
            state_prev <= state;
            if (inc_btn)
                inc_cnt <= '0;
            else if (state_chg)
                inc_cnt <= ONE_C;
            else if (both_low)
                inc_cnt <= inc_cnt;
            else if (inc_cnt == DELAY_C)
                inc_cnt <= RELOAD_C;
            else
                inc_cnt <= inc_cnt + ONE_C;
        end
    end

`ifdef DEC_BTN_EN
    logic             dec_prev;
    logic [CNT_W-1:0] dec_cnt;
    logic             dec_ev_raw;

    assign both_low   = !inc_btn && !dec_btn;
    assign dec_ev_raw = (!dec_btn && dec_prev) ||
                        (!dec_btn && !state_chg && !both_low && dec_cnt == DELAY_C);
    assign inc_ev     = inc_ev_raw && !dec_ev_raw;
    assign dec_ev     = dec_ev_raw && !inc_ev_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_prev <= 1'b1;
            dec_cnt  <= '0;
        end else begin
            dec_prev <= dec_btn;
            if (dec_btn)
                dec_cnt <= '0;
            else if (state_chg)
                dec_cnt <= ONE_C;
            else if (both_low)
                dec_cnt <= dec_cnt;
            else if (dec_cnt == DELAY_C)
                dec_cnt <= RELOAD_C;
            else
                dec_cnt <= dec_cnt + ONE_C;
        end
    end
`else
    assign both_low = 1'b0;
    assign inc_ev   = inc_ev_raw;
    assign dec_ev   = 1'b0;
`endif

    assign next_val   = dec_ev ? dec_val : inc_val;
    assign accept     = (inc_ev || dec_ev) && edit_active && (fsm == IDLE);
    assign settle_dim = dim(date_month, date_year);
    assign busy       = (fsm != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            wr_en     <= 1'b0;
            wr_target <= '0;
            wr_field  <= '0;
            wr_data   <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    wr_en <= 1'b0;
                    if (accept) begin
                        wr_target <= rd_target;
                        wr_field  <= rd_field;
                        wr_data   <= next_val;
                        wr_en     <= 1'b1;
                        fsm       <= WRITE;
                    end
                end
                WRITE: begin
                    wr_en <= 1'b0;
                    fsm   <= (wr_target == 2'd0 && (wr_field == 3'd4 || wr_field == 3'd5))
                             ? SETTLE : IDLE;
                end
                // Storage now holds the new month/year; re-check the stored day against it.
                SETTLE: begin
                    if ({2'b00, date_day} > settle_dim) begin
                        wr_field <= 3'd3;
                        wr_data  <= settle_dim;
                        wr_en    <= 1'b1;
                        fsm      <= CLAMP;
                    end else begin
                        fsm <= IDLE;
                    end
                end
                CLAMP: begin
                    wr_en <= 1'b0;
                    fsm   <= IDLE;
                end
                default: begin
                    wr_en <= 1'b0;
                    fsm   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/field_edit_ctrl.md
Name: field_edit_ctrl

Overview:
- Sequences field increments for the clock's edit states.
- Decodes the 4-bit mode-state code into a target register bank and a field, and detects presses of the active-low increment button, with auto-repeat while held.
- Computes the wrapped next value and issues single-cycle write strobes to the time/date, alarm and timer storage.
- After a month or year edit, runs a follow-up clamp so the stored day stays valid.

Parameters:
- REPEAT_DELAY, 10_000_000: cycles the button is held before the first auto-repeat event.
- REPEAT_PERIOD, 2_000_000: cycles between later auto-repeat events. Must be ≥ 4.
- CNT_W, 24: width of the hold counter. Must hold REPEAT_DELAY.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- state  in  4  mode-state code: 2..7 time/date edit, 9..11 alarm edit, 13..15 timer edit, all others display
- inc_btn  in  1  increment button, active-low, already synchronised and debounced
- rd_data  in  7  current binary value of field (rd_target, rd_field), returned combinationally
- date_day  in  5  stored day, 1..31
- date_month  in  4  stored month, 1..12
- date_year  in  7  stored year, 0..99 (represents 2000..2099)
- rd_target  out  2  bank select, combinational from state: 0 time/date, 1 alarm, 2 timer
- rd_field  out  3  field select, combinational: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year
- wr_en  out  1  one-cycle write strobe
- wr_target  out  2  bank of the write
- wr_field  out  3  field of the write
- wr_data  out  7  value to write
- busy  out  1  high whenever the FSM is not in IDLE
- edit_active  out  1  high when state is an edit state

Behaviour:
- Reset: all registered outputs are 0 and the FSM is in IDLE. The button history register resets to 1 (released) and the hold counter to 0.
- Decode, edit states only:
  - 2→(0,0), 3→(0,1), 4→(0,2), 5→(0,3), 6→(0,4), 7→(0,5).
  - 9/10/11→(1,0/1/2).
  - 13/14/15→(2,0/1/2).
  - In non-edit states rd_target = 0, rd_field = 0 and edit_active = 0.
- Press event: inc_btn low in this cycle and high in the previous cycle.
- Auto-repeat:
  - The hold counter counts while inc_btn is low.
  - An event fires when the counter reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles after that.
  - Releasing the button clears the counter.
  - Any change of state while the button is held clears the counter without generating an event.
- Events are ignored when edit_active = 0 or busy = 1. They are dropped, not queued.
- Wrap rules for next = rd_data + 1:
  - sec/min: 59→0.
  - hour: 23→0, timer bank included.
  - day: dim→1.
  - month: 12→1.
  - year: 99→0.
  - rd_data above the field maximum, or day/month equal to 0, writes the field minimum.
- dim (days in month): 31 or 30 by month; February is 29 when year%4 == 0, else 28.
- FSM:
  - IDLE: on an accepted event, register wr_target/wr_field/wr_data and go to WRITE.
  - WRITE: wr_en = 1 for exactly one cycle, i.e. the cycle after the event. If the bank is 0 and the field is month or year, go to SETTLE; otherwise go to IDLE.
  - SETTLE: storage has now updated. Register need = (date_day > dim(date_month, date_year)). If need, load wr_field = 3 and wr_data = dim, then go to CLAMP; otherwise go to IDLE.
  - CLAMP: wr_en = 1 for one cycle with the day clamp, then go to IDLE.
- wr_en is 0 in every other cycle. wr_target/wr_field/wr_data hold their values between writes.
- A change of state mid-sequence does not abort the sequence; the write already captured completes.
- An asynchronous rst at any point returns the block to IDLE. No partial write is emitted after reset.

Optional Feature:
- Macro DEC_BTN_EN.
- When defined, the block adds input dec_btn (1 bit, active-low) with its own edge detect and its own auto-repeat counter, using the same parameters.
- Decrement wraps: sec/min 0→59, hour 0→23, day 1→dim, month 1→12, year 0→99. Month and year decrements also trigger the clamp sequence.
- If both buttons produce an event in the same cycle, neither is applied. While both buttons are held, both hold counters are frozen.
- When undefined, dec_btn does not exist and only increment is supported.

Test Plan:
- Benches use REPEAT_DELAY = 20 and REPEAT_PERIOD = 5.
1. rst asserted mid-WRITE → wr_en, busy and wr_* all 0 on the next edge; IDLE after release.
2. state = 2, rd_data = 59, single press → exactly one wr_en, one cycle after the edge, with (0,0,0). state = 4, rd_data = 23 → data 0.
3. state = 6, rd_data = 1, storage reflects the write (month 2, year 23, day 31) → WRITE (0,4,2), two cycles later CLAMP write (0,3,28). Same with year 24 → day 29.
4. state = 3, hold inc_btn 40 cycles → writes at the press, at +20, +25, +30, +35. Changing state to 4 at cycle 22 → no event until 20 cycles after the change.
5. state = 0 or state = 8, press → no wr_en, edit_active = 0. Press during busy → dropped, exactly one write.
6. DEC_BTN_EN defined: state = 7, rd_data = 0, dec press → write (0,5,99), then clamp check. Both buttons pressed in the same cycle → no write.
